// File: rtl/interface_hcsr04_multi.sv
// Round-robin controller for up to eight HC-SR04 ultrasonic sensors: triggers each
// sensor in turn, times its echo in centimetres and publishes distance, floor band and validity.
module interface_hcsr04_multi #(
  parameter int N_SENS         = 2,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2941,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int LOOP_CYCLES    = 3000000,
  parameter int FLOOR_CM       = 10,
  parameter int ANDAR_W        = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ligado,
  input  logic [N_SENS-1:0]           echo,
  output logic [N_SENS-1:0]           trigger,
  output logic [N_SENS*10-1:0]        distancia,
  output logic [N_SENS*ANDAR_W-1:0]   andar,
  output logic [N_SENS-1:0]           valido,
  output logic                        pronto,
  output logic [2:0]                  canal,
  output logic [3:0]                  db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ESPERA_LOOP = 4'd1,
    PREPARA     = 4'd2,
    GERA        = 4'd3,
    ESPERA_ECHO = 4'd4,
    MEDINDO     = 4'd5,
    REGISTRA    = 4'd6,
    PROXIMO     = 4'd7,
    TIMEOUT     = 4'd8
  } state_t;

  localparam int TICK_MAX  = (TRIG_CYCLES > CM_CYCLES) ? TRIG_CYCLES : CM_CYCLES;
  localparam int TICK_W    = $clog2(TICK_MAX + 1);
  localparam int LOOP_W    = $clog2(LOOP_CYCLES + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ANDAR_MAX = (1 << ANDAR_W) - 1;

  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TICK_W-1:0] TRIG_LAST = TICK_W'(TRIG_CYCLES - 1);
  localparam logic [TICK_W-1:0] CM_LAST   = TICK_W'(CM_CYCLES - 1);
  localparam logic [2:0]        CH_LAST   = 3'(N_SENS - 1);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  function automatic logic [ANDAR_W-1:0] floor_code(input logic [9:0] cm);
    int q;
    q = int'(cm) / FLOOR_CM;
    if (q > ANDAR_MAX) q = ANDAR_MAX;
    return ANDAR_W'(q);
  endfunction

  state_t                           state_q;
  logic [2:0]                       canal_q;
  logic [LOOP_W-1:0]                loop_q;
  logic [TICK_W-1:0]                tick_q;
  logic [TO_W-1:0]                  to_q;
  logic [9:0]                       cm_q;
  logic [N_SENS-1:0]                trigger_q;
  logic [N_SENS-1:0][9:0]           distancia_q;
  logic [N_SENS-1:0][ANDAR_W-1:0]   andar_q;
  logic [N_SENS-1:0]                valido_q;
  logic                             pronto_q;

  logic                             echo_d;
  logic [9:0]                       cm_d;
  logic [ANDAR_W-1:0]               andar_d;

  // Only the serviced channel's echo is ever looked at.
  always_comb begin
    echo_d = 1'b0;
    for (int i = 0; i < N_SENS; i++)
      if (canal_q == 3'(i)) echo_d = echo[i];
  end

  assign cm_d    = sat_inc(cm_q);
  assign andar_d = floor_code(cm_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INICIAL;
      canal_q     <= '0;
      loop_q      <= '0;
      tick_q      <= '0;
      to_q        <= '0;
      cm_q        <= '0;
      trigger_q   <= '0;
      distancia_q <= '0;
      andar_q     <= '0;
      valido_q    <= '0;
      pronto_q    <= 1'b0;
    end else if (!ligado) begin
      state_q   <= INICIAL;
      loop_q    <= '0;
      tick_q    <= '0;
      to_q      <= '0;
      cm_q      <= '0;
      trigger_q <= '0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      // Round timer runs freely from round start and sticks at its last value on overrun.
      if (state_q != INICIAL && loop_q != LOOP_LAST) loop_q <= loop_q + LOOP_W'(1);

      case (state_q)
        INICIAL: begin
          state_q <= ESPERA_LOOP;
          loop_q  <= '0;
        end
        ESPERA_LOOP: begin
          if (loop_q == LOOP_LAST) begin
            state_q <= PREPARA;
            canal_q <= '0;
            loop_q  <= '0;
          end
        end
        PREPARA: begin
          cm_q    <= '0;
          tick_q  <= '0;
          to_q    <= '0;
          for (int i = 0; i < N_SENS; i++)
            if (canal_q == 3'(i)) trigger_q[i] <= 1'b1;
          state_q <= GERA;
        end
        GERA: begin
          if (tick_q == TRIG_LAST) begin
            tick_q    <= '0;
            trigger_q <= '0;
            state_q   <= ESPERA_ECHO;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        ESPERA_ECHO, MEDINDO: begin
          to_q <= to_q + TO_W'(1);
          if (to_q == TO_LAST) begin
            state_q <= TIMEOUT;
          end else if (echo_d) begin
            // The clock that sees echo high counts, so a stale echo is timed from entry.
            state_q <= MEDINDO;
            if (tick_q == CM_LAST) begin
              tick_q <= '0;
              cm_q   <= cm_d;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end else if (state_q == MEDINDO) begin
            state_q <= REGISTRA;
          end
        end
        REGISTRA: begin
          for (int i = 0; i < N_SENS; i++)
            if (canal_q == 3'(i)) begin
              distancia_q[i] <= cm_q;
              andar_q[i]     <= andar_d;
              valido_q[i]    <= 1'b1;
            end
          pronto_q <= 1'b1;
          state_q  <= PROXIMO;
        end
        TIMEOUT: begin
          for (int i = 0; i < N_SENS; i++)
            if (canal_q == 3'(i)) valido_q[i] <= 1'b0;
          pronto_q <= 1'b1;
          state_q  <= PROXIMO;
        end
        PROXIMO: begin
          if (canal_q != CH_LAST) begin
            canal_q <= canal_q + 3'd1;
            state_q <= PREPARA;
          end else if (loop_q == LOOP_LAST) begin
            canal_q <= '0;
            loop_q  <= '0;
            state_q <= PREPARA;
          end else begin
            state_q <= ESPERA_LOOP;
          end
        end
        default: state_q <= INICIAL;
      endcase
    end
  end

  assign trigger   = trigger_q;
  assign distancia = distancia_q;
  assign andar     = andar_q;
  assign valido    = valido_q;
  assign pronto    = pronto_q;
  assign canal     = canal_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Directed bench for interface_hcsr04_multi: a table of per-sensor echo scenarios
// followed by hand-written enable-drop and asynchronous-reset sequences.
module tb_interface_hcsr04_multi;

  localparam int N_SENS         = 2;
  localparam int TRIG_CYCLES    = 5;
  localparam int CM_CYCLES      = 4;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int LOOP_CYCLES    = 2000;
  localparam int FLOOR_CM       = 10;
  localparam int ANDAR_W        = 2;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      ligado;
  logic [N_SENS-1:0]         echo;
  logic [N_SENS-1:0]         trigger;
  logic [N_SENS*10-1:0]      distancia;
  logic [N_SENS*ANDAR_W-1:0] andar;
  logic [N_SENS-1:0]         valido;
  logic                      pronto;
  logic [2:0]                canal;
  logic [3:0]                db_estado;

  interface_hcsr04_multi #(
    .N_SENS(N_SENS), .TRIG_CYCLES(TRIG_CYCLES), .CM_CYCLES(CM_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LOOP_CYCLES(LOOP_CYCLES),
    .FLOOR_CM(FLOOR_CM), .ANDAR_W(ANDAR_W)
  ) dut (
    .clock(clock), .reset(reset), .ligado(ligado), .echo(echo),
    .trigger(trigger), .distancia(distancia), .andar(andar), .valido(valido),
    .pronto(pronto), .canal(canal), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic overlap_seen = 1'b0;
  always @(negedge clock) if (trigger === 2'b11) overlap_seen <= 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ch;
    int len;       // echo-high clocks; 0 means the echo never rises
    bit noise;     // also pulse the other channel's echo
    int exp_dist;
    int exp_andar;
    int exp_val;
  } vec_t;

  vec_t tbl[6];
  int   m_dist[N_SENS];
  int   m_andar[N_SENS];
  int   m_val[N_SENS];
  longint rise_t[6];

  function automatic logic [N_SENS*10-1:0] exp_dist_vec();
    return {10'(m_dist[1]), 10'(m_dist[0])};
  endfunction
  function automatic logic [N_SENS*ANDAR_W-1:0] exp_andar_vec();
    return {2'(m_andar[1]), 2'(m_andar[0])};
  endfunction
  function automatic logic [N_SENS-1:0] exp_val_vec();
    return {1'(m_val[1]), 1'(m_val[0])};
  endfunction

  task automatic wait_trig_rise(input int ch, output longint t);
    int cnt;
    cnt = 0;
    while (trigger[ch] !== 1'b1 && cnt < 5000) begin
      @(negedge clock);
      cnt++;
    end
    check("trig_rise_seen", (cnt < 5000), 1);
    t = cyc;
  endtask

  task automatic run_vec(input vec_t v, output longint t);
    int cnt;
    int other;
    other = 1 - v.ch;
    wait_trig_rise(v.ch, t);
    check("canal_at_trig", canal, v.ch);
    cnt = 0;
    while (trigger[v.ch] === 1'b1 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    check("trig_width", cnt, TRIG_CYCLES);
    check("state_after_trig", db_estado, 4);
    if (v.len > 0) begin
      echo[v.ch] = 1'b1;
      if (v.noise) echo[other] = 1'b1;
      repeat (v.len) @(negedge clock);
      echo = '0;
    end else begin
      cnt = 0;
      while (db_estado !== 4'd8 && cnt < 1000) begin
        cnt++;
        @(negedge clock);
      end
      check("timeout_clocks", cnt, TIMEOUT_CYCLES);
    end
    cnt = 0;
    while (pronto !== 1'b1 && cnt < 1000) begin
      @(negedge clock);
      cnt++;
    end
    check("pronto_seen", (cnt < 1000), 1);
    check("canal_at_pronto", canal, v.ch);
    check("dist_ch", distancia[v.ch*10 +: 10], v.exp_dist);
    check("andar_ch", andar[v.ch*ANDAR_W +: ANDAR_W], v.exp_andar);
    check("valido_ch", valido[v.ch], v.exp_val);
    check("dist_other", distancia[other*10 +: 10], m_dist[other]);
    check("valido_other", valido[other], m_val[other]);
    @(negedge clock);
    check("pronto_one_clock", pronto, 0);
    m_dist[v.ch]  = v.exp_dist;
    m_andar[v.ch] = v.exp_andar;
    m_val[v.ch]   = v.exp_val;
  endtask

  initial begin
    longint t;
    tbl[0] = '{ch: 0, len: 100, noise: 1'b0, exp_dist: 25, exp_andar: 2, exp_val: 1};
    tbl[1] = '{ch: 1, len: 240, noise: 1'b0, exp_dist: 60, exp_andar: 3, exp_val: 1};
    tbl[2] = '{ch: 0, len: 0,   noise: 1'b0, exp_dist: 25, exp_andar: 2, exp_val: 0};
    tbl[3] = '{ch: 1, len: 41,  noise: 1'b1, exp_dist: 10, exp_andar: 1, exp_val: 1};
    tbl[4] = '{ch: 0, len: 3,   noise: 1'b0, exp_dist: 0,  exp_andar: 0, exp_val: 1};
    tbl[5] = '{ch: 1, len: 39,  noise: 1'b0, exp_dist: 9,  exp_andar: 0, exp_val: 1};
    for (int i = 0; i < N_SENS; i++) begin
      m_dist[i] = 0; m_andar[i] = 0; m_val[i] = 0;
    end

    reset  = 1'b1;
    ligado = 1'b0;
    echo   = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_state", db_estado, 0);
    check("rst_trigger", trigger, 0);
    check("rst_distancia", distancia, 0);
    check("rst_andar", andar, 0);
    check("rst_valido", valido, 0);
    check("rst_pronto", pronto, 0);
    check("rst_canal", canal, 0);
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    ligado = 1'b1;
    @(negedge clock);
    check("enable_to_espera_loop", db_estado, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], t);
      rise_t[i] = t;
    end
    check("round_period_1", rise_t[2] - rise_t[0], LOOP_CYCLES);
    check("round_period_2", rise_t[4] - rise_t[2], LOOP_CYCLES);

    // Enable dropped while measuring: results must survive.
    wait_trig_rise(0, t);
    while (trigger[0] === 1'b1 && cyc < t + 50) @(negedge clock);
    echo[0] = 1'b1;
    repeat (20) @(negedge clock);
    check("state_medindo", db_estado, 5);
    ligado = 1'b0;
    @(negedge clock);
    check("off_state", db_estado, 0);
    check("off_trigger", trigger, 0);
    check("off_distancia", distancia, exp_dist_vec());
    check("off_andar", andar, exp_andar_vec());
    check("off_valido", valido, exp_val_vec());
    echo = '0;
    repeat (3) @(negedge clock);
    check("off_holds_inicial", db_estado, 0);

    // Asynchronous reset in the middle of a trigger pulse.
    ligado = 1'b1;
    @(negedge clock);
    check("reenable_state", db_estado, 1);
    wait_trig_rise(0, t);
    @(negedge clock);
    check("mid_gera_state", db_estado, 3);
    #2 reset = 1'b0;
    #1;
    check("async_trigger", trigger, 0);
    check("async_state", db_estado, 0);
    check("async_distancia", distancia, 0);
    check("async_andar", andar, 0);
    check("async_valido", valido, 0);
    check("async_pronto", pronto, 0);
    check("async_canal", canal, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_state", db_estado, 1);

    check("trig_overlap", overlap_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
